// File: rtl/mp3_status_receiver_if.sv
// Bus between the MP3 Trigger status receiver and its host: serial line in, decoded events out.
interface mp3_status_receiver_if;
    logic       rx;
    logic       play_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       track_done;
    logic       track_stopped;
    logic       play_error;
    logic       playing;

    modport master (
        output rx, play_start,
        input  rx_data, rx_valid, frame_error, track_done, track_stopped, play_error, playing
    );

    modport slave (
        input  rx, play_start,
        output rx_data, rx_valid, frame_error, track_done, track_stopped, play_error, playing
    );
endinterface

// File: rtl/mp3_status_receiver.sv
// 8N1 UART receiver for MP3 Trigger status bytes, decoding 'X', 'x' and 'E' into
// one-cycle event pulses and tracking a playing level.
module mp3_status_receiver #(
    parameter int unsigned CLKS_PER_BIT = 1302
) (
    input  logic                 clock,
    input  logic                 reset,
    mp3_status_receiver_if.slave bus
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          rx_meta, rx_sync;
    logic          load, ferr;
    logic          clear_play;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        bit_next   = bit_idx;
        shift_next = shift;
        load       = 1'b0;
        ferr       = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_sync) begin
                    state_next = START;
                    bit_next   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_next = '0;
                    if (rx_sync) begin
                        load       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr       = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_sync) state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Clearing uses the registered event pulses, so a play_start in the pulse cycle wins.
    assign clear_play = bus.track_done | bus.track_stopped | bus.play_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.rx_data       <= '0;
            bus.rx_valid      <= 1'b0;
            bus.frame_error   <= 1'b0;
            bus.track_done    <= 1'b0;
            bus.track_stopped <= 1'b0;
            bus.play_error    <= 1'b0;
            bus.playing       <= 1'b0;
        end else begin
            if (load) bus.rx_data <= shift;
            bus.rx_valid      <= load;
            bus.frame_error   <= ferr;
            bus.track_done    <= load && (shift == 8'h58);
            bus.track_stopped <= load && (shift == 8'h78);
            bus.play_error    <= load && (shift == 8'h45);
            if (bus.play_start)  bus.playing <= 1'b1;
            else if (clear_play) bus.playing <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mp3_status_receiver.sv
// Directed bench for mp3_status_receiver at 16 clocks per bit.
module tb_mp3_status_receiver;
    localparam int unsigned CPB = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mp3_status_receiver_if bus ();

    mp3_status_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_valid = 0, n_ferr = 0, n_td = 0, n_ts = 0, n_pe = 0, n_orphan = 0;
    int t_valid = 0, t_valid_prev = 0, t_ts = 0, t_td = 0;
    int v0, f0, td0, ts0, pe0;
    bit found;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.rx_valid) begin
            n_valid      <= n_valid + 1;
            t_valid_prev <= t_valid;
            t_valid      <= cyc;
        end
        if (bus.frame_error)   n_ferr <= n_ferr + 1;
        if (bus.track_done)    begin n_td <= n_td + 1; t_td <= cyc; end
        if (bus.track_stopped) begin n_ts <= n_ts + 1; t_ts <= cyc; end
        if (bus.play_error)    n_pe <= n_pe + 1;
        if ((bus.track_done | bus.track_stopped | bus.play_error) && !bus.rx_valid)
            n_orphan <= n_orphan + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d, input int nbits);
        bus.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < nbits; i++) begin
            bus.rx = d[i];
            tick(CPB);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bits(d, 8);
        bus.rx = stop;
        tick(CPB);
    endtask

    task automatic snap();
        v0 = n_valid; f0 = n_ferr; td0 = n_td; ts0 = n_ts; pe0 = n_pe;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx = 1'b1;
        bus.play_start = 1'b0;
        tick(5);

        // Reset values, and play_start during reset ignored
        chk("reset_rx_data", bus.rx_data, 8'h00);
        chk("reset_pulses", {bus.rx_valid, bus.frame_error, bus.track_done,
                             bus.track_stopped, bus.play_error}, 5'b0);
        bus.play_start = 1'b1;
        tick(1);
        bus.play_start = 1'b0;
        chk("reset_play_start_ignored", bus.playing, 1'b0);
        reset = 1'b0;
        tick(5);
        chk("after_reset_playing", bus.playing, 1'b0);

        // 0x58 clears playing and fires track_done
        bus.play_start = 1'b1;
        tick(1);
        bus.play_start = 1'b0;
        chk("play_set_1", bus.playing, 1'b1);
        snap();
        send_byte(8'h58, 1'b1);
        tick(8);
        chk("x58_rx_data", bus.rx_data, 8'h58);
        chk("x58_valid_count", n_valid - v0, 1);
        chk("x58_td_count", n_td - td0, 1);
        chk("x58_others", (n_ts - ts0) + (n_pe - pe0) + (n_ferr - f0), 0);
        chk("x58_playing_cleared", bus.playing, 1'b0);

        // play_start then 'E'
        bus.play_start = 1'b1;
        tick(1);
        bus.play_start = 1'b0;
        chk("play_set_2", bus.playing, 1'b1);
        snap();
        send_byte(8'h45, 1'b1);
        tick(8);
        chk("x45_rx_data", bus.rx_data, 8'h45);
        chk("x45_pe_count", n_pe - pe0, 1);
        chk("x45_valid_count", n_valid - v0, 1);
        chk("x45_playing_cleared", bus.playing, 1'b0);

        // Framing error, line held low, then 'x'
        snap();
        send_byte(8'h41, 1'b0);
        tick(40);
        bus.rx = 1'b1;
        tick(3 * CPB);
        chk("ferr_count", n_ferr - f0, 1);
        chk("ferr_no_valid", n_valid - v0, 0);
        chk("ferr_rx_data_kept", bus.rx_data, 8'h45);
        snap();
        send_byte(8'h78, 1'b1);
        tick(8);
        chk("x78_after_ferr_ts", n_ts - ts0, 1);
        chk("x78_after_ferr_valid", n_valid - v0, 1);
        chk("x78_rx_data", bus.rx_data, 8'h78);

        // 5-cycle glitch on idle line
        snap();
        bus.rx = 1'b0;
        tick(5);
        bus.rx = 1'b1;
        tick(4 * CPB);
        chk("glitch_no_pulses", (n_valid - v0) + (n_ferr - f0) + (n_td - td0)
                                + (n_ts - ts0) + (n_pe - pe0), 0);

        // Plain byte: rx_valid only
        snap();
        send_byte(8'h41, 1'b1);
        tick(8);
        chk("x41_valid", n_valid - v0, 1);
        chk("x41_no_decode", (n_td - td0) + (n_ts - ts0) + (n_pe - pe0), 0);
        chk("x41_rx_data", bus.rx_data, 8'h41);

        // Back-to-back 'x' then 'X'
        snap();
        send_byte(8'h78, 1'b1);
        send_byte(8'h58, 1'b1);
        tick(8);
        chk("b2b_valid_count", n_valid - v0, 2);
        chk("b2b_valid_spacing", t_valid - t_valid_prev, 160);
        chk("b2b_ts_count", n_ts - ts0, 1);
        chk("b2b_td_count", n_td - td0, 1);
        chk("b2b_order", t_td - t_ts, 160);
        chk("b2b_rx_data", bus.rx_data, 8'h58);

        // Reset during bit 4 abandons the byte
        bus.play_start = 1'b1;
        tick(1);
        bus.play_start = 1'b0;
        snap();
        send_bits(8'h58, 4);
        bus.rx = 1'b1;
        tick(CPB / 2);
        reset = 1'b1;
        tick(3);
        chk("midreset_rx_data", bus.rx_data, 8'h00);
        chk("midreset_playing", bus.playing, 1'b0);
        chk("midreset_pulses", {bus.rx_valid, bus.frame_error, bus.track_done,
                                bus.track_stopped, bus.play_error}, 5'b0);
        reset = 1'b0;
        tick(12 * CPB);
        chk("midreset_no_pulses", (n_valid - v0) + (n_ferr - f0) + (n_td - td0)
                                  + (n_ts - ts0) + (n_pe - pe0), 0);
        chk("midreset_rx_data_after", bus.rx_data, 8'h00);

        // play_start coincident with track_done keeps playing high
        send_bits(8'h58, 8);
        bus.rx = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clock);
            if (bus.track_done) begin
                found = 1'b1;
                break;
            end
        end
        chk("coincide_td_seen", found, 1'b1);
        bus.play_start = 1'b1;
        @(posedge clock);
        #1;
        bus.play_start = 1'b0;
        chk("coincide_playing", bus.playing, 1'b1);
        tick(CPB);
        chk("coincide_playing_hold", bus.playing, 1'b1);
        chk("coincide_rx_data", bus.rx_data, 8'h58);

        chk("decode_without_valid", n_orphan, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mp3_status_receiver.md
MP3_STATUS_RECEIVER -- requirements
Module: mp3_status_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1302, SHALL be the clock cycles per serial bit (50 MHz / 38400 baud), legal range 8..65535.
REQ-002 clock  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 rx  input  1  SHALL be the serial line from the MP3 Trigger TX pin: 8N1, LSB first, idle high, asynchronous to clock.
REQ-005 play_start  input  1  SHALL be a one-cycle pulse issued when a trigger command is driven to the MP3 Trigger.
REQ-006 rx_data  output  8  SHALL hold the last correctly framed byte.
REQ-007 rx_valid  output  1  SHALL pulse for one cycle when rx_data updates.
REQ-008 frame_error  output  1  SHALL pulse for one cycle when a stop bit samples low.
REQ-009 track_done  output  1  SHALL pulse for one cycle on receipt of byte 0x58 ('X').
REQ-010 track_stopped  output  1  SHALL pulse for one cycle on receipt of byte 0x78 ('x').
REQ-011 play_error  output  1  SHALL pulse for one cycle on receipt of byte 0x45 ('E').
REQ-012 playing  output  1  SHALL be a level: high while a track is believed to be playing.

Function
REQ-013 rx SHALL pass through a two-flop synchronizer preset to 1; all logic SHALL use the synchronized value only.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, and WAIT_HIGH.
REQ-015 IDLE: synchronized rx = 0 SHALL enter START and clear the bit counter.
REQ-016 START: after CLKS_PER_BIT/2 cycles (integer division), rx = 0 SHALL enter DATA; rx = 1 SHALL be treated as a glitch and return to IDLE with no output pulse.
REQ-017 DATA: each bit SHALL be sampled after CLKS_PER_BIT cycles, shifted in LSB first; after the 8th sample the FSM SHALL enter STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, sampled 1 SHALL load rx_data and return to IDLE; sampled 0 SHALL discard the byte and enter WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL remain until synchronized rx = 1, then enter IDLE; no start bit SHALL be accepted while in WAIT_HIGH.
REQ-020 rx_valid, frame_error and the decode pulses SHALL assert on the clock edge following the stop-bit sample, together with the rx_data update, for exactly one cycle.
REQ-021 Decode pulses SHALL fire only together with rx_valid; any other byte value SHALL produce rx_valid alone.
REQ-022 playing SHALL set on play_start and clear on track_done, track_stopped or play_error.
REQ-023 If play_start coincides with a clearing pulse, playing SHALL be 1.
REQ-024 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 at every state transition.
REQ-025 Back-to-back bytes (start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-026 While reset is high: state = IDLE, counters = 0, synchronizer flops = 1, rx_data = 0x00, playing = 0, all pulse outputs = 0.
REQ-027 Reset asserted mid-byte SHALL abandon the byte with no output pulse; reception SHALL restart only on the next falling edge seen in IDLE.
REQ-028 A play_start coincident with reset SHALL be ignored.

Verification (CLKS_PER_BIT = 16)
REQ-029 Send 0x58 with a valid stop bit -> rx_data = 0x58, rx_valid and track_done high for one cycle; if playing was 1 it clears.
REQ-030 Pulse play_start, then send 0x45 -> playing 0->1, then play_error pulse and playing returns to 0.
REQ-031 Send 0x41 with the stop bit forced to 0 -> frame_error pulse, rx_data unchanged, no rx_valid; after rx is held low 40 cycles then released, the next 0x78 decodes as track_stopped.
REQ-032 Drive a 5-cycle low glitch on idle rx -> no pulses, FSM returns to IDLE.
REQ-033 Send 0x78 and 0x58 back-to-back -> two rx_valid pulses exactly 160 cycles apart, track_stopped then track_done.
REQ-034 Assert reset during bit 4 of a byte, with play_start and track_done coincident in a separate cycle -> no pulses from the aborted byte, all outputs at reset values, and playing = 1 after the coincident cycle.
